// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage (and the fetch stage that feeds it).
// Holds the opcode encodings, instruction field bit positions and the execute FSM
// state encoding.
package execute_stage_pkg;

    // Opcodes, instruction[31:26]
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ADD  = 6'b010000;
    localparam logic [5:0] OP_SW   = 6'b111000;
    localparam logic [5:0] OP_MUL  = 6'b100000;
    localparam logic [5:0] OP_NOP  = 6'b000000;

    // Instruction field positions
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [0:0] {
        StIdle,
        StMulBusy
    } exec_state_e;

endpackage

// File: rtl/iterative_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, DATA_W cycles.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (aborts any operation)
//   start       - load operands a/b and begin (ignored while busy)
//   a, b        - operands
//   done        - high during the last busy cycle; product is valid in that cycle
//   product     - low DATA_W bits of a*b, valid while done is high
module iterative_multiplier #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  count_q;
    logic              busy_q;
    logic [DATA_W-1:0] partial;

    assign partial = mplier_q[0] ? mcand_q : '0;
    // The final step's sum is presented combinationally so the consumer can
    // write it on the same edge the multiplier goes idle.
    assign product = acc_q + partial;
    assign done    = busy_q && (count_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else if (busy_q) begin
            if (done) begin
                busy_q <= 1'b0;
            end else begin
                acc_q    <= product;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q + 1'b1;
            end
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: decodes ADDI/ADD/SW/MUL, reads/writes a local register file and
// data memory, and reports each completed writeback one cycle later.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   instruction   - 32-bit instruction word from fetch
//   instr_valid   - instruction is valid this cycle
//   ready         - stage can accept; low while a MUL is in flight (stalls fetch)
//   result_valid  - one-cycle pulse describing a completed writeback
//   result        - value written (store data for SW)
//   wr_addr       - destination register (store address for SW)
//   is_store      - the result_valid pulse is a store completion
//   illegal_op    - one-cycle pulse for an accepted undefined nonzero opcode
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned DMEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    output logic              ready,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        wr_addr,
    output logic              is_store,
    output logic              illegal_op
);

    localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);

    exec_state_e       state_q;
    logic              ready_q;
    logic              result_valid_q;
    logic [DATA_W-1:0] result_q;
    logic [4:0]        wr_addr_q;
    logic              is_store_q;
    logic              illegal_op_q;
    logic [4:0]        mul_rd_q;

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

    logic [5:0]         op;
    logic [4:0]         rs, rt, rd;
    logic [15:0]        imm;
    logic [DATA_W-1:0]  sext_imm, rs_val, rt_val;
    logic [DATA_W-1:0]  addi_sum, add_sum, store_ea;
    logic [DMEM_AW-1:0] store_addr;
    logic               accept, mul_start, mul_done;
    logic [DATA_W-1:0]  mul_product;

    assign op       = instruction[OP_MSB:OP_LSB];
    assign rs       = instruction[RS_MSB:RS_LSB];
    assign rt       = instruction[RT_MSB:RT_LSB];
    assign rd       = instruction[RD_MSB:RD_LSB];
    assign imm      = instruction[IMM_MSB:IMM_LSB];
    assign sext_imm = {{(DATA_W - 16){imm[15]}}, imm};

    // Reads see the register array after the previous edge's write, so a
    // dependent instruction in the next cycle needs no forwarding.
    assign rs_val = (rs == 5'd0) ? '0 : regs_q[rs];
    assign rt_val = (rt == 5'd0) ? '0 : regs_q[rt];

    assign addi_sum   = rs_val + sext_imm;
    assign add_sum    = rs_val + rt_val;
    assign store_ea   = rt_val + sext_imm;
    assign store_addr = store_ea[DMEM_AW-1:0];

    assign accept    = instr_valid && ready_q;
    assign mul_start = accept && (state_q == StIdle) && (op == OP_MUL);

    iterative_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (rs_val),
        .b       (rt_val),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            ready_q        <= 1'b1;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            wr_addr_q      <= '0;
            is_store_q     <= 1'b0;
            illegal_op_q   <= 1'b0;
            mul_rd_q       <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
        end else begin
            result_valid_q <= 1'b0;
            is_store_q     <= 1'b0;
            illegal_op_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        case (op)
                            OP_ADDI: begin
                                if (rt != 5'd0) regs_q[rt] <= addi_sum;
                                result_valid_q <= 1'b1;
                                result_q       <= addi_sum;
                                wr_addr_q      <= rt;
                            end
                            OP_ADD: begin
                                if (rd != 5'd0) regs_q[rd] <= add_sum;
                                result_valid_q <= 1'b1;
                                result_q       <= add_sum;
                                wr_addr_q      <= rd;
                            end
                            OP_SW: begin
                                dmem_q[store_addr] <= rs_val;
                                result_valid_q     <= 1'b1;
                                is_store_q         <= 1'b1;
                                result_q           <= rs_val;
                                wr_addr_q          <= 5'(store_addr);
                            end
                            OP_MUL: begin
                                mul_rd_q <= rd;
                                ready_q  <= 1'b0;
                                state_q  <= StMulBusy;
                            end
                            OP_NOP: ;
                            default: illegal_op_q <= 1'b1;
                        endcase
                    end
                end
                StMulBusy: begin
                    if (mul_done) begin
                        if (mul_rd_q != 5'd0) regs_q[mul_rd_q] <= mul_product;
                        result_valid_q <= 1'b1;
                        result_q       <= mul_product;
                        wr_addr_q      <= mul_rd_q;
                        ready_q        <= 1'b1;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready        = ready_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign wr_addr      = wr_addr_q;
    assign is_store     = is_store_q;
    assign illegal_op   = illegal_op_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        ready;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  wr_addr;
    logic        is_store;
    logic        illegal_op;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .ready        (ready),
        .result_valid (result_valid),
        .result       (result),
        .wr_addr      (wr_addr),
        .is_store     (is_store),
        .illegal_op   (illegal_op)
    );

    typedef struct {
        bit          illegal;
        bit          store;
        logic [4:0]  addr;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'b0};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drive one instruction at the next negedge once ready; returns 1ns after the accept edge.
    task automatic send(input logic [31:0] w, input bit push, input exp_t e);
        int waited = 0;
        @(negedge clk);
        while (!ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (!ready) begin
            n_fail++;
            $display("FAIL %s: ready stayed 0 for %0d cycles, expected 1", e.name, waited);
        end
        if (push) sbq.push_back(e);
        instruction = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instruction = '0;
    endtask

    task automatic wr(input string nm, input logic [31:0] w, input logic [4:0] a,
                      input logic [31:0] d);
        exp_t e;
        e.illegal = 0; e.store = 0; e.addr = a; e.data = d; e.name = nm;
        send(w, 1'b1, e);
    endtask

    task automatic st(input string nm, input logic [31:0] w, input logic [4:0] a,
                      input logic [31:0] d);
        exp_t e;
        e.illegal = 0; e.store = 1; e.addr = a; e.data = d; e.name = nm;
        send(w, 1'b1, e);
    endtask

    task automatic ill(input string nm, input logic [31:0] w);
        exp_t e;
        e.illegal = 1; e.store = 0; e.addr = '0; e.data = '0; e.name = nm;
        send(w, 1'b1, e);
    endtask

    task automatic quiet(input string nm, input logic [31:0] w);
        exp_t e;
        e.illegal = 0; e.store = 0; e.addr = '0; e.data = '0; e.name = nm;
        send(w, 1'b0, e);
    endtask

    // Monitor: every output pulse must match the oldest expected response.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (result_valid || illegal_op)) begin
            n_tests++;
            if (result_valid && illegal_op) begin
                n_fail++;
                $display("FAIL both_pulses: result_valid=1 illegal_op=1, expected one at most");
            end else if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: rv=%0b ill=%0b addr=%0d data=0x%08h, expected none",
                         result_valid, illegal_op, wr_addr, result);
            end else begin
                e = sbq.pop_front();
                if (illegal_op != e.illegal ||
                    (!e.illegal && (is_store != e.store || wr_addr != e.addr ||
                                    result != e.data))) begin
                    n_fail++;
                    $display("FAIL %s: got ill=%0b st=%0b addr=%0d data=0x%08h, expected ill=%0b st=%0b addr=%0d data=0x%08h",
                             e.name, illegal_op, is_store, wr_addr, result,
                             e.illegal, e.store, e.addr, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cnt;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'b0, ready}, 32'd1);
        check("reset_result_valid", {31'b0, result_valid}, 32'd0);
        check("reset_illegal", {31'b0, illegal_op}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_wr_addr", {27'b0, wr_addr}, 32'd0);

        // Reference program
        wr("addi_r10", itype(OP_ADDI, 5'd0, 5'd10, 16'd10), 5'd10, 32'd10);
        wr("addi_r15", itype(OP_ADDI, 5'd0, 5'd15, 16'd15), 5'd15, 32'd15);
        wr("add_r25", rtype(OP_ADD, 5'd10, 5'd15, 5'd25), 5'd25, 32'd25);
        st("sw_dmem5", itype(OP_SW, 5'd25, 5'd20, 16'd5), 5'd5, 32'd25);
        wr("addi_r5", itype(OP_ADDI, 5'd0, 5'd5, 16'd2), 5'd5, 32'd2);
        wr("mul_r30", rtype(OP_MUL, 5'd25, 5'd5, 5'd30), 5'd30, 32'd50);
        cnt = 0;
        @(negedge clk);
        while (!ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("mul_ready_low_cycles", cnt, 32'd32);

        // R0 write discarded but reported
        wr("addi_r0", itype(OP_ADDI, 5'd0, 5'd0, 16'd7), 5'd0, 32'd7);
        wr("read_r0", rtype(OP_ADD, 5'd0, 5'd10, 5'd3), 5'd3, 32'd10);

        // Illegal opcode: pulse only, no state change
        ill("illegal_000111", itype(6'b000111, 5'd0, 5'd10, 16'd99));
        check("illegal_ready_now", {31'b0, ready}, 32'd1);
        wr("r10_unchanged", rtype(OP_ADD, 5'd10, 5'd0, 5'd4), 5'd4, 32'd10);
        quiet("nop", 32'd0);

        // Wrap-around arithmetic and store address modulo
        wr("addi_neg1", itype(OP_ADDI, 5'd0, 5'd1, 16'hFFFF), 5'd1, 32'hFFFF_FFFF);
        wr("add_wrap", rtype(OP_ADD, 5'd1, 5'd1, 5'd2), 5'd2, 32'hFFFF_FFFE);
        st("sw_neg_off", itype(OP_SW, 5'd1, 5'd5, 16'hFFFF), 5'd1, 32'hFFFF_FFFF);
        st("sw_mod16", itype(OP_SW, 5'd5, 5'd30, 16'd0), 5'd2, 32'd2);
        wr("mul_wrap", rtype(OP_MUL, 5'd1, 5'd1, 5'd6), 5'd6, 32'd1);

        // Reset in the middle of a MUL: no writeback expected
        quiet("mul_aborted", rtype(OP_MUL, 5'd25, 5'd5, 5'd30));
        repeat (10) @(negedge clk);
        check("mid_mul_ready", {31'b0, ready}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {31'b0, ready}, 32'd1);
        repeat (40) @(negedge clk);
        wr("r30_r25_cleared", rtype(OP_ADD, 5'd30, 5'd25, 5'd3), 5'd3, 32'd0);
        wr("r1_r10_cleared", rtype(OP_ADD, 5'd1, 5'd10, 5'd4), 5'd4, 32'd0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
